// File: rtl/spi_pkg.sv
// Shared encodings and helpers for the SPI serial shift engine.
package spi_pkg;

  typedef enum logic [1:0] {
    LEN_8  = 2'b00,
    LEN_16 = 2'b01,
    LEN_24 = 2'b10,
    LEN_32 = 2'b11
  } len_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    FINISH = 2'b10
  } state_e;

  // Frame length in bits: 8*(data_len+1).
  function automatic logic [5:0] len_bits(input logic [1:0] data_len);
    logic [2:0] bytes;
    bytes = {1'b0, data_len} + 3'd1;
    return {bytes, 3'b000};
  endfunction

endpackage

// File: rtl/spi_edge_detect.sv
// Turns the clk_cpu-synchronous internal SCK level into single-cycle rise/fall pulses.
module spi_edge_detect (
  input  logic clk_cpu,
  input  logic rst,
  input  logic sck_inter,
  output logic rise,
  output logic fall
);

  logic sck_q;

  always_ff @(posedge clk_cpu or posedge rst) begin
    if (rst) sck_q <= 1'b0;
    else     sck_q <= sck_inter;
  end

  assign rise = sck_inter & ~sck_q;
  assign fall = ~sck_inter & sck_q;

endmodule

// File: rtl/spi_shift_engine.sv
// SPI serial datapath: shifts the TX frame out on mosi and captures miso into rx_data.
// Optional build macro SPI_LOOPBACK_EN adds a loopback input that samples mosi instead of miso.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_cpu,
  input  logic                  rst,
  input  logic                  sck_inter,
  input  logic                  load_data,
  input  logic [1:0]            data_len,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  miso,
`ifdef SPI_LOOPBACK_EN
  input  logic                  loopback,
`endif
  output logic                  mosi,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  done,
  output logic                  busy
);

  state_e                state;
  logic                  load_q;
  logic [5:0]            bit_cnt;
  logic [5:0]            len;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic [DATA_WIDTH-1:0] rx_sr;
  logic [DATA_WIDTH-1:0] rx_sr_next;
  logic                  rise;
  logic                  fall;
  logic                  start;
  logic                  sample;
  logic [5:0]            start_len;

  spi_edge_detect u_edge (
    .clk_cpu  (clk_cpu),
    .rst      (rst),
    .sck_inter(sck_inter),
    .rise     (rise),
    .fall     (fall)
  );

  assign start     = load_data & ~load_q;
  assign start_len = len_bits(data_len);
  assign mosi      = (state == SHIFT) ? tx_sr[DATA_WIDTH-1] : 1'b0;

`ifdef SPI_LOOPBACK_EN
  assign sample = loopback ? mosi : miso;
`else
  assign sample = miso;
`endif

  // Upper bits stay zero because rx_sr is cleared at start and shifted exactly N times.
  assign rx_sr_next = (rx_sr << 1) | {{(DATA_WIDTH-1){1'b0}}, sample};

  always_ff @(posedge clk_cpu or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      load_q  <= 1'b0;
      bit_cnt <= '0;
      len     <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rx_data <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      load_q <= load_data;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            len     <= start_len;
            tx_sr   <= tx_data << (DATA_WIDTH - int'(start_len));
            bit_cnt <= '0;
            rx_sr   <= '0;
            state   <= SHIFT;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          // Abort takes priority, including over the final rise.
          if (!load_data) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (rise) begin
            rx_sr   <= rx_sr_next;
            bit_cnt <= bit_cnt + 6'd1;
            if (bit_cnt + 6'd1 == len) begin
              rx_data <= rx_sr_next;
              done    <= 1'b1;
              state   <= FINISH;
            end
          end else if (fall && bit_cnt != 6'd0) begin
            tx_sr <= tx_sr << 1;
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed self-checking bench for spi_shift_engine.
module tb_spi_shift_engine;

  logic        clk_cpu = 1'b0;
  logic        rst;
  logic        sck_inter;
  logic        load_data;
  logic [1:0]  data_len;
  logic [31:0] tx_data;
  logic        miso;
  logic        loopback;
  logic        mosi;
  logic [31:0] rx_data;
  logic        done;
  logic        busy;

  int checks   = 0;
  int fails    = 0;
  int done_cnt = 0;

  spi_shift_engine #(.DATA_WIDTH(32)) dut (
    .clk_cpu  (clk_cpu),
    .rst      (rst),
    .sck_inter(sck_inter),
    .load_data(load_data),
    .data_len (data_len),
    .tx_data  (tx_data),
    .miso     (miso),
`ifdef SPI_LOOPBACK_EN
    .loopback (loopback),
`endif
    .mosi     (mosi),
    .rx_data  (rx_data),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk_cpu = ~clk_cpu;

  always @(negedge clk_cpu) if (done) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sck_cycle();
    sck_inter = 1'b1;
    @(negedge clk_cpu);
    @(negedge clk_cpu);
    sck_inter = 1'b0;
    @(negedge clk_cpu);
    @(negedge clk_cpu);
  endtask

  // Runs a full frame; leaves load_data high on return.
  task automatic transfer(input string tag, input logic [1:0] len, input logic [31:0] tx,
                          input logic [31:0] rxw, input bit tie,
                          input logic [31:0] exp_rx, input logic [31:0] exp_mosi);
    int          n;
    int          d0;
    logic [31:0] mw;
    n  = 8 * (int'(len) + 1);
    mw = '0;
    d0 = done_cnt;
    data_len  = len;
    tx_data   = tx;
    load_data = 1'b1;
    @(negedge clk_cpu);
    chk({tag, " busy_after_start"}, 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      mw = {mw[30:0], mosi};
      miso = tie ? mosi : rxw[n-1-i];
      sck_inter = 1'b1;
      @(negedge clk_cpu);
      if (i == n - 2) chk({tag, " done_early"}, 32'(done), 32'd0);
      if (i == n - 1) begin
        chk({tag, " done_pulse"}, 32'(done), 32'd1);
        chk({tag, " busy_finish"}, 32'(busy), 32'd1);
        chk({tag, " rx_data"}, rx_data, exp_rx);
      end
      @(negedge clk_cpu);
      if (i == n - 1) begin
        chk({tag, " done_cleared"}, 32'(done), 32'd0);
        chk({tag, " busy_cleared"}, 32'(busy), 32'd0);
      end
      sck_inter = 1'b0;
      @(negedge clk_cpu);
      @(negedge clk_cpu);
    end
    chk({tag, " mosi_word"}, mw, exp_mosi);
    chk({tag, " done_count"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int d0;
    rst       = 1'b1;
    sck_inter = 1'b0;
    load_data = 1'b0;
    data_len  = 2'b00;
    tx_data   = '0;
    miso      = 1'b0;
    loopback  = 1'b0;
    @(negedge clk_cpu);
    @(negedge clk_cpu);
    chk("reset mosi", 32'(mosi), 32'd0);
    chk("reset rx_data", rx_data, 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk_cpu);

    transfer("len8", 2'b00, 32'h000000A5, 32'h0, 1'b1, 32'h000000A5, 32'h000000A5);
    load_data = 1'b0;
    @(negedge clk_cpu);

    transfer("len32", 2'b11, 32'hDEADBEEF, 32'h12345678, 1'b0, 32'h12345678, 32'hDEADBEEF);
    load_data = 1'b0;
    @(negedge clk_cpu);

    transfer("len16", 2'b01, 32'hFFFF1234, 32'hFFFFFFFF, 1'b0, 32'h0000FFFF, 32'h00001234);
    load_data = 1'b0;
    @(negedge clk_cpu);

    // Abort after five rises of an 8-bit frame.
    d0 = done_cnt;
    data_len  = 2'b00;
    tx_data   = 32'h000000FF;
    miso      = 1'b1;
    load_data = 1'b1;
    @(negedge clk_cpu);
    for (int i = 0; i < 5; i++) sck_cycle();
    chk("abort busy_before", 32'(busy), 32'd1);
    chk("abort mosi_before", 32'(mosi), 32'd1);
    load_data = 1'b0;
    @(negedge clk_cpu);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort mosi", 32'(mosi), 32'd0);
    chk("abort rx_data_kept", rx_data, 32'h0000FFFF);
    for (int i = 0; i < 4; i++) sck_cycle();
    chk("abort no_done", 32'(done_cnt - d0), 32'd0);

    // Level-high load_data across completion must not retrigger.
    transfer("retrig", 2'b00, 32'h0000005A, 32'h0, 1'b1, 32'h0000005A, 32'h0000005A);
    d0 = done_cnt;
    for (int i = 0; i < 10; i++) sck_cycle();
    chk("retrig no_second_done", 32'(done_cnt - d0), 32'd0);
    chk("retrig busy_idle", 32'(busy), 32'd0);
    load_data = 1'b0;
    @(negedge clk_cpu);
    transfer("retoggle", 2'b00, 32'h00000081, 32'h0000007E, 1'b0, 32'h0000007E, 32'h00000081);
    load_data = 1'b0;
    @(negedge clk_cpu);

    // Asynchronous reset at bit 10 of a 16-bit frame.
    data_len  = 2'b01;
    tx_data   = 32'h0000FFFF;
    miso      = 1'b0;
    load_data = 1'b1;
    @(negedge clk_cpu);
    for (int i = 0; i < 10; i++) sck_cycle();
    chk("rstmid busy_before", 32'(busy), 32'd1);
    chk("rstmid mosi_before", 32'(mosi), 32'd1);
    #2;
    rst       = 1'b1;
    load_data = 1'b0;
    #1;
    chk("rstmid mosi", 32'(mosi), 32'd0);
    chk("rstmid rx_data", rx_data, 32'd0);
    chk("rstmid busy", 32'(busy), 32'd0);
    chk("rstmid done", 32'(done), 32'd0);
    @(negedge clk_cpu);
    rst = 1'b0;
    @(negedge clk_cpu);
    transfer("post_rst", 2'b00, 32'h0000003C, 32'h000000C3, 1'b0, 32'h000000C3, 32'h0000003C);
    load_data = 1'b0;
    @(negedge clk_cpu);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/spi_shift_engine.md
Name: spi_shift_engine

Overview:
- Serial datapath stage directly downstream of the SPI control FSM.
- Consumes the FSM's internal SCK, load_data, reordered TX word and data length.
- Shifts the TX word out on MOSI and the RX word in from MISO.
- Returns done and the raw RX word to the FSM and bit-order logic.
- Runs entirely in the clk_cpu domain; SCK edges are detected as clk_cpu-synchronous events.

Parameters:
- DATA_WIDTH, 32, shift register width. Only 32 is supported; length encoding assumes it.

Ports:
- clk_cpu  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- sck_inter  in  1  internal SCK (phase-adjusted), generated synchronously from clk_cpu
- load_data  in  1  transfer request level from the control FSM
- data_len  in  2  frame length: bits = 8*(data_len+1), so 00=8 and 11=32
- tx_data  in  32  reordered TX word; frame is tx_data[N-1:0], sent MSB (bit N-1) first
- miso  in  1  serial input
- mosi  out  1  serial output
- rx_data  out  32  received word, zero-extended above bit N-1
- done  out  1  one-cycle completion pulse
- busy  out  1  transfer in progress

Behaviour:
- Reset values: mosi=0, rx_data=0, done=0, busy=0, state=IDLE, sck_q=0, load_q=0, bit_cnt=0, shift regs=0.
- Edge detect: sck_q <= sck_inter; rise = sck_inter & ~sck_q; fall = ~sck_inter & sck_q.
- Start: start = load_data & ~load_q. Level-high load_data never retriggers.
- IDLE:
  - On start: latch len N from data_len, tx_sr <= tx_data << (32-N), bit_cnt <= 0, rx_sr <= 0, go to SHIFT.
  - busy rises in the next cycle.
- mosi = tx_sr[31] while in SHIFT, so the first bit is valid before the first rise. mosi = 0 in IDLE.
- SHIFT:
  - On rise: rx_sr <= {rx_sr[30:0], miso}, bit_cnt++.
  - On fall with bit_cnt != 0: tx_sr <= tx_sr << 1. This launches the next bit.
  - A rise that makes bit_cnt == N moves the FSM to FINISH.
- FINISH (one cycle): rx_data <= rx_sr (zero-extended), done=1, busy=1, then IDLE.
- Abort: load_data low in SHIFT → IDLE next cycle. No done pulse, rx_data unchanged, mosi=0.
- Ignored requests: start while busy is ignored. data_len and tx_data changes after the start cycle are ignored.
- Simultaneous abort and final rise: abort wins.
- Latency: done is the clk_cpu cycle after the clock edge that captured the Nth rise.
- bit_cnt: 6-bit, never wraps (max 32).
- Mid-transfer rst: immediate return to reset values. The next transfer needs a fresh load_data rise.

Optional Feature:
- Macro SPI_LOOPBACK_EN.
- Defined:
  - Adds input loopback (1 bit).
  - When loopback=1 the sampled bit is mosi instead of miso; mosi pin still toggles.
- Undefined:
  - Port absent; miso is always sampled.

Decomposition:
- Package spi_pkg: length encodings LEN_8..LEN_32, state encodings IDLE/SHIFT/FINISH, function len_bits(data_len).
- Sub-module spi_edge_detect: sck_inter → rise/fall pulses. Reused by the clock divider bench.

Test Plan:
- 8-bit:
  - Stimulus: data_len=00, tx_data=0x000000A5, miso tied to mosi.
  - Response: mosi sequence 1,0,1,0,0,1,0,1; done 1 cycle after 8th rise; rx_data=0x000000A5.
- 32-bit:
  - Stimulus: data_len=11, tx_data=0xDEADBEEF, miso driven with 0x12345678 MSB-first.
  - Response: rx_data=0x12345678; exactly 32 rises counted; one done pulse.
- 16-bit:
  - Stimulus: data_len=01, tx_data=0xFFFF1234, miso=1.
  - Response: mosi emits 0x1234; rx_data=0x0000FFFF.
- Abort:
  - Stimulus: drop load_data after 5 rises.
  - Response: IDLE next cycle, no done, rx_data keeps previous value, busy=0.
- Retrigger:
  - Stimulus: load_data held high across completion.
  - Response: single done, no second transfer; a low-high toggle starts a new one.
- Reset mid-shift:
  - Stimulus: rst pulse at bit 10.
  - Response: all outputs zero asynchronously; a subsequent 8-bit transfer completes normally.
